csa_accum: RTL and testbench
============================

Name: csa_accum

Overview:
- Parametrised carry-save multi-operand accumulator; successor to the fixed 32-bit 4:2 sum/majority compressor.
- Each accepted beat carries NOPS operands of WIDTH bits.
- Operands are compressed together with the running carry-save state (sum, carry) using 3:2 sum/majority stages.
- On the last beat of a packet, the carry-save pair is resolved by one carry-propagate add and presented on a valid/ready output.
- Sits between operand-producing datapaths and the result consumer in the arithmetic cosim harness.

Parameters:
- WIDTH, 32, bit width of operands, state registers and result; legal 4..128.
- NOPS, 4, operands per input beat; legal 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_ops  input  NOPS*WIDTH  operands; operand k = in_ops[k*WIDTH +: WIDTH].
- in_last  input  1  final beat of packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  resolved packet sum, modulo 2^WIDTH.

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, sum_q=0, carry_q=0, out_valid=0, out_sum=0; in_ready=1 after reset.
- Reset asserted mid-packet or mid-hold: all state is discarded immediately; no partial result is ever emitted.
- Compression per accepted beat:
  - Vectors = {sum_q, carry_q, op0..op(NOPS-1)}, where sum_q and carry_q are replaced by 0 if state==IDLE.
  - Reduce the vectors to two with a tree of 3:2 stages.
    - Each stage: s = a^b^c; c' = ((a&b)|(b&c)|(a&c)) << 1.
    - Each shift is truncated to WIDTH bits (MSB dropped).
  - Register the final pair into sum_q/carry_q.
  - Whole tree is combinational within one cycle.
- States: IDLE, ACCUM, RESOLVE, HOLD.
  - IDLE: in_ready=1. Accept with in_last=0 -> ACCUM. Accept with in_last=1 -> RESOLVE.
  - ACCUM: in_ready=1. Accept with in_last=0 -> stay. Accept with in_last=1 -> RESOLVE.
  - RESOLVE: in_ready=0. out_sum <= sum_q + carry_q (mod 2^WIDTH); out_valid <= 1 -> HOLD.
  - HOLD: in_ready=0; out_valid=1; out_sum stable.
    - out_ready=1 -> out_valid<=0, sum_q/carry_q<=0 -> IDLE.
    - out_ready=0 -> stay; out_sum and out_valid held.
- Latency: last beat accepted at edge t -> out_valid high after edge t+1 (visible in cycle t+1..t+2 window, i.e. 2 clocks after the beat is presented).
- Throughput: one beat/cycle while accumulating. Minimum gap between packets is 2 cycles (RESOLVE plus the HOLD handoff).
- Boundary cases:
  - in_valid=0 in ACCUM holds state indefinitely.
  - in_ops is ignored when not accepted.
  - out_ready asserted before out_valid has no effect.
  - Arithmetic wrap-around is silent (mod 2^WIDTH) unless the optional feature is enabled.
  - Single-beat packet (IDLE with in_last=1) is legal.
  - NOPS=1 degenerates to a single 3:2 stage per beat.

Optional Feature:
- Macro: CSA_ACCUM_OVF_EN.
- Defined:
  - Extra output port out_ovf (1 bit), reset 0, valid alongside out_sum.
  - Internal counter ovf_q (width clog2(NOPS*2+2)+WIDTH-agnostic, 8 bits) accumulates the count of carry bits dropped at every truncating shift plus the carry-out of the final resolve add.
  - out_ovf=1 iff the true integer packet sum ≥ 2^WIDTH, i.e. ovf_q nonzero at resolve.
  - ovf_q is cleared with sum_q/carry_q.
  - Counter saturates at max.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package csa_pkg:
  - csa_state_e enum (IDLE, ACCUM, RESOLVE, HOLD).
  - Functions csa_sum3 and csa_maj3, parametrised via a WIDTH-wide typedef in the instantiating module.
  - localparam helper for tree depth.
- One sub-module csa_tree: combinational reducer of NOPS+2 WIDTH-bit vectors to a sum/carry pair (and dropped-carry count under CSA_ACCUM_OVF_EN).
- csa_accum holds the FSM, registers and resolve adder.

Test Plan:
- Reset/idle: rst_n low for 3 cycles, then high -> out_valid=0, out_sum=0, in_ready=1; no transitions while in_valid=0.
- Single-beat packet, WIDTH=32, NOPS=4: ops {1,2,3,4}, last=1 -> out_sum=10 two cycles later; in_ready=0 until out_ready handshake.
- Multi-beat with backpressure: 3 beats of ops {0xFFFF_FFFF,1,0,0}, last on 3rd; hold out_ready=0 for 5 cycles -> out_sum=0 stable and out_valid held. Under CSA_ACCUM_OVF_EN, out_ovf=1.
- Bubbles: beats {5,5,5,5}, gap of 4 idle cycles, then {1,0,0,0} last -> out_sum=21.
- Reset mid-packet: two beats accepted, rst_n pulsed low asynchronously -> out_valid=0 immediately. Next packet {7,0,0,0} last -> out_sum=7, showing no residue.
- Parameter sweep: WIDTH=8, NOPS=1, beats 200,100 last -> out_sum=44 (mod 256); out_ovf=1 when enabled.

Source files
------------

// File: rtl/csa_accum_pkg.sv
// csa_pkg: shared types and bit-level helpers for the carry-save accumulator.
// Optional feature macro used by the modules that import this package:
// CSA_ACCUM_OVF_EN.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } csa_state_e;

  // Upper bound on operands per beat; the dropped-carry count fits in 4 bits.
  localparam int CSA_MAX_OPS = 8;

  // Sum bit of a 3:2 compressor. The helpers are bitwise so any module can
  // apply them across its own WIDTH-wide word type.
  function automatic logic csa_sum3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Majority (carry) bit of a 3:2 compressor, before the left shift.
  function automatic logic csa_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // Number of 3:2 stages needed to fold NOPS operands into the running pair.
  // Each operand consumes exactly one stage because the running pair always
  // supplies two of the three inputs.
  function automatic int csa_tree_depth(input int nops);
    return nops;
  endfunction

endpackage

// File: rtl/csa_accum_tree.sv
// csa_tree: combinational reducer of {sum, carry, op0..op(NOPS-1)} down to a
// carry-save pair using one 3:2 stage per operand. Carries shifted out of the
// MSB are discarded; with CSA_ACCUM_OVF_EN defined their count is reported on
// drop_cnt so the accumulator can flag a sum that exceeded 2^WIDTH.
module csa_tree
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NOPS  = 4
) (
  input  logic [WIDTH-1:0]      sum_in,
  input  logic [WIDTH-1:0]      carry_in,
  input  logic [NOPS*WIDTH-1:0] ops,
  output logic [WIDTH-1:0]      sum_out,
  output logic [WIDTH-1:0]      carry_out
`ifdef CSA_ACCUM_OVF_EN
  ,
  output logic [3:0]            drop_cnt
`endif
);

  typedef logic [WIDTH-1:0] word_t;

`ifdef CSA_ACCUM_OVF_EN
  logic [NOPS-1:0] drop;
`endif

  genvar gi, gb;
  for (gi = 0; gi < NOPS; gi++) begin : g_stage
    word_t s_in, c_in, s_out, c_out, op;

    assign op = ops[gi*WIDTH +: WIDTH];

    if (gi == 0) begin : g_first
      assign s_in = sum_in;
      assign c_in = carry_in;
    end else begin : g_next
      assign s_in = g_stage[gi-1].s_out;
      assign c_in = g_stage[gi-1].c_out;
    end

    // The shifted carry vector always has a zero LSB; the MSB majority falls off.
    assign c_out[0] = 1'b0;
    for (gb = 0; gb < WIDTH; gb++) begin : g_bit
      assign s_out[gb] = csa_sum3(s_in[gb], c_in[gb], op[gb]);
      if (gb < WIDTH - 1) begin : g_carry
        assign c_out[gb+1] = csa_maj3(s_in[gb], c_in[gb], op[gb]);
      end
    end

`ifdef CSA_ACCUM_OVF_EN
    assign drop[gi] = csa_maj3(s_in[WIDTH-1], c_in[WIDTH-1], op[WIDTH-1]);
`endif
  end

  assign sum_out   = g_stage[NOPS-1].s_out;
  assign carry_out = g_stage[NOPS-1].c_out;

`ifdef CSA_ACCUM_OVF_EN
  // Population count of the carries discarded in this beat.
  always_comb begin
    drop_cnt = '0;
    for (int k = 0; k < NOPS; k++) begin
      drop_cnt = drop_cnt + 4'(drop[k]);
    end
  end
`endif

endmodule

// File: rtl/csa_accum.sv
// csa_accum: parametrised carry-save multi-operand accumulator. Beats of NOPS
// operands are folded into a registered carry-save pair; the last beat of a
// packet triggers one carry-propagate add and a valid/ready result.
// Optional macro CSA_ACCUM_OVF_EN adds out_ovf (packet sum >= 2^WIDTH).
module csa_accum
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NOPS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NOPS*WIDTH-1:0] in_ops,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum
`ifdef CSA_ACCUM_OVF_EN
  ,
  output logic                  out_ovf
`endif
);

  csa_state_e       state_reg, state_next;
  logic [WIDTH-1:0] sum_q, carry_q;
  logic [WIDTH-1:0] tree_sum_in, tree_carry_in;
  logic [WIDTH-1:0] tree_sum, tree_carry;
  logic             accept, release_hold;

  assign accept       = in_valid && in_ready;
  assign release_hold = (state_reg == HOLD) && out_ready;

  // A new packet starts from a clean pair regardless of stale register contents.
  assign tree_sum_in   = (state_reg == IDLE) ? '0 : sum_q;
  assign tree_carry_in = (state_reg == IDLE) ? '0 : carry_q;

`ifdef CSA_ACCUM_OVF_EN
  logic [3:0]       drop_cnt;
  logic [7:0]       ovf_q;
  logic [7:0]       ovf_base;
  logic [8:0]       ovf_acc;
  logic [WIDTH:0]   resolve_full;

  assign resolve_full = {1'b0, sum_q} + {1'b0, carry_q};
  assign ovf_base     = (state_reg == IDLE) ? 8'd0 : ovf_q;
  assign ovf_acc      = {1'b0, ovf_base} + 9'(drop_cnt);
`else
  logic [WIDTH-1:0] resolve_sum;

  assign resolve_sum = sum_q + carry_q;
`endif

  csa_tree #(
    .WIDTH (WIDTH),
    .NOPS  (NOPS)
  ) u_tree (
    .sum_in    (tree_sum_in),
    .carry_in  (tree_carry_in),
    .ops       (in_ops),
    .sum_out   (tree_sum),
    .carry_out (tree_carry)
`ifdef CSA_ACCUM_OVF_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Next-state and input handshake decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? RESOLVE : ACCUM;
      end
      RESOLVE: state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Carry-save pair: loaded on each accepted beat, cleared on result handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (accept) begin
      sum_q   <= tree_sum;
      carry_q <= tree_carry;
    end else if (release_hold) begin
      sum_q   <= '0;
      carry_q <= '0;
    end
  end

  // Result register: resolved once, then held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (state_reg == RESOLVE) begin
      out_valid <= 1'b1;
`ifdef CSA_ACCUM_OVF_EN
      out_sum   <= resolve_full[WIDTH-1:0];
`else
      out_sum   <= resolve_sum;
`endif
    end else if (release_hold) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CSA_ACCUM_OVF_EN
  // Saturating count of every 2^WIDTH carry lost during the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= '0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      ovf_q <= ovf_acc[8] ? 8'hFF : ovf_acc[7:0];
    end else if (state_reg == RESOLVE) begin
      out_ovf <= (ovf_q != 8'd0) || resolve_full[WIDTH];
      ovf_q   <= (ovf_q == 8'hFF) ? 8'hFF : ovf_q + 8'(resolve_full[WIDTH]);
    end else if (release_hold) begin
      ovf_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: scoreboard bench for csa_accum (WIDTH=32/NOPS=4 plus a
// WIDTH=8/NOPS=1 instance). Define CSA_ACCUM_OVF_EN to also check out_ovf.
module tb_csa_accum;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_ops = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_sum;

  logic         v8 = 1'b0;
  logic         r8;
  logic [7:0]   ops8 = '0;
  logic         l8 = 1'b0;
  logic         ov8;
  logic         ordy8 = 1'b0;
  logic [7:0]   sum8;

`ifdef CSA_ACCUM_OVF_EN
  logic         out_ovf;
  logic         ovf8;
`endif

  int           checks = 0;
  int           failures = 0;
  logic [63:0]  pkt_total = '0;
  exp_t         exp_q[$];
  exp_t         exp8_q[$];

  csa_accum #(.WIDTH(32), .NOPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
`ifdef CSA_ACCUM_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  csa_accum #(.WIDTH(8), .NOPS(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .in_ready  (r8),
    .in_ops    (ops8),
    .in_last   (l8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_sum   (sum8)
`ifdef CSA_ACCUM_OVF_EN
    ,
    .out_ovf   (ovf8)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Present one beat for one clock; the model total is pushed on the last beat.
  task automatic send_beat(input logic [31:0] o0, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3,
                           input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_ops   = {o3, o2, o1, o0};
    in_last  = last;
    pkt_total = pkt_total + 64'(o0) + 64'(o1) + 64'(o2) + 64'(o3);
    if (last) begin
      exp_q.push_back('{pkt_total[31:0], (pkt_total >= 64'h1_0000_0000)});
      pkt_total = '0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ops   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Count falling edges until out_valid; -1 if it never rises.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_sum !== 32'd0) begin failures++; $display("FAIL reset_out_sum got=%0d want=0", out_sum); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (ov8 !== 1'b0 || sum8 !== 8'd0 || r8 !== 1'b1) begin failures++; $display("FAIL reset_dut8 got=%b/%0d/%b want=0/0/1", ov8, sum8, r8); end
`ifdef CSA_ACCUM_OVF_EN
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b want=0", out_ovf); end
`endif
    for (int i = 0; i < 4; i++) begin
      in_ops = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_hold got=%b/%b want=1/0", in_ready, out_valid); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_beat();
    int lat;
    exp_t e;
    send_beat(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency got=%0d want=1", lat); end
    checks++; if (out_sum !== e.sum) begin failures++; $display("FAIL single_sum got=%0d want=%0d", out_sum, e.sum); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_in_ready_hold got=%b want=0", in_ready); end
`ifdef CSA_ACCUM_OVF_EN
    checks++; if (out_ovf !== e.ovf) begin failures++; $display("FAIL single_ovf got=%b want=%b", out_ovf, e.ovf); end
`endif
    consume();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL single_release got=%b/%b want=0/1", out_valid, in_ready); end
    $display("test_single_beat sum=%0d want=%0d", out_sum, e.sum);
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    for (int b = 0; b < 3; b++) send_beat(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, (b == 2));
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL bp_latency got=%0d want=1", lat); end
`ifdef CSA_ACCUM_OVF_EN
    checks++; if (out_ovf !== e.ovf) begin failures++; $display("FAIL bp_ovf got=%b want=%b", out_ovf, e.ovf); end
`endif
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_sum !== e.sum || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cycle=%0d got=%b/%0d/%b want=1/%0d/0", i, out_valid, out_sum, in_ready, e.sum);
      end
      in_valid = 1'b1;
      in_ops   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
    $display("test_backpressure sum=%0d want=%0d", out_sum, e.sum);
  endtask

  task automatic test_bubbles();
    int lat;
    exp_t e;
    send_beat(32'd5, 32'd5, 32'd5, 32'd5, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ops = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bubble_hold got=%b/%b want=1/0", in_ready, out_valid); end
    end
    send_beat(32'd1, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL bubble_latency got=%0d want=1", lat); end
    checks++; if (out_sum !== e.sum) begin failures++; $display("FAIL bubble_sum got=%0d want=%0d", out_sum, e.sum); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bubble_release got=%b/%b want=0/1", out_valid, in_ready); end
    $display("test_bubbles sum=%0d want=%0d", out_sum, e.sum);
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_t e;
    send_beat(32'd9, 32'd9, 32'd9, 32'd9, 1'b0);
    send_beat(32'd9, 32'd9, 32'd9, 32'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midpkt_reset got=%b/%b want=0/1", out_valid, in_ready); end
    pkt_total = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(32'd3, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_valid(lat);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sum !== 32'd0) begin failures++; $display("FAIL midhold_reset got=%b/%0d want=0/0", out_valid, out_sum); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL residue_latency got=%0d want=1", lat); end
    checks++; if (out_sum !== e.sum) begin failures++; $display("FAIL residue_sum got=%0d want=%0d", out_sum, e.sum); end
`ifdef CSA_ACCUM_OVF_EN
    checks++; if (out_ovf !== e.ovf) begin failures++; $display("FAIL residue_ovf got=%b want=%b", out_ovf, e.ovf); end
`endif
    consume();
    $display("test_reset_mid sum=%0d want=%0d", out_sum, e.sum);
  endtask

  task automatic test_back_to_back();
    int lat;
    int nb;
    exp_t e;
    for (int p = 0; p < 6; p++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) send_beat($urandom, $urandom, $urandom, $urandom, (b == nb - 1));
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_latency pkt=%0d got=%0d want=1", p, lat); end
      checks++; if (out_sum !== e.sum) begin failures++; $display("FAIL b2b_sum pkt=%0d got=%h want=%h", p, out_sum, e.sum); end
`ifdef CSA_ACCUM_OVF_EN
      checks++; if (out_ovf !== e.ovf) begin failures++; $display("FAIL b2b_ovf pkt=%0d got=%b want=%b", p, out_ovf, e.ovf); end
`endif
      $display("test_back_to_back pkt=%0d beats=%0d sum=%h want=%h", p, nb, out_sum, e.sum);
      consume();
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] tot;
    logic [7:0]  vals [4];
    int          lat;
    exp_t        e;
    vals[0] = 8'd200; vals[1] = 8'd100; vals[2] = 8'd100; vals[3] = 8'd50;
    for (int p = 0; p < 2; p++) begin
      tot = 32'(vals[2*p]) + 32'(vals[2*p+1]);
      exp8_q.push_back('{{24'd0, tot[7:0]}, (tot >= 32'd256)});
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        v8 = 1'b1; ops8 = vals[2*p+b]; l8 = (b == 1);
        @(posedge clk);
        #1;
        v8 = 1'b0; l8 = 1'b0; ops8 = 8'($urandom);
      end
      lat = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ov8 === 1'b1) begin lat = i; break; end
      end
      e = exp8_q.pop_front();
      checks++; if (lat !== 1) begin failures++; $display("FAIL w8_latency pkt=%0d got=%0d want=1", p, lat); end
      checks++; if (32'(sum8) !== e.sum) begin failures++; $display("FAIL w8_sum pkt=%0d got=%0d want=%0d", p, sum8, e.sum); end
`ifdef CSA_ACCUM_OVF_EN
      checks++; if (ovf8 !== e.ovf) begin failures++; $display("FAIL w8_ovf pkt=%0d got=%b want=%b", p, ovf8, e.ovf); end
`endif
      $display("test_param_sweep pkt=%0d sum=%0d want=%0d", p, sum8, e.sum);
      @(negedge clk);
      ordy8 = 1'b1;
      @(posedge clk);
      #1;
      ordy8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_back_to_back();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
